mem_port_arbiter: RTL and testbench

//  Shares one single-port, variable-latency memory between the pipeline's IF stage (instruction fetch)
//  and its MEM stage (load/store). It serialises the two requesters with a 4-state FSM and holds one

---
 rtl/mem_port_arbiter.sv | 170 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one single-port, variable-latency memory between the instruction
// fetch (IF) and load/store (MEM) pipeline stages. Data accesses win
// arbitration, but a starvation counter forces a fetch after MAX_DATA_BURST
// back-to-back data grants while a fetch is waiting. Only one access is
// outstanding at a time.
module mem_port_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int MAX_DATA_BURST = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              stall_if,
    output logic              stall_mem
);

    localparam int CNT_W = $clog2(MAX_DATA_BURST + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_DATA_BURST);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_D  = 2'd2,
        RESP    = 2'd3
    } state_t;

    state_t            state_r,     state_s;
    logic [CNT_W-1:0]  cnt_r,       cnt_s;
    logic              mem_req_r,   mem_req_s;
    logic              mem_we_r,    mem_we_s;
    logic [ADDR_W-1:0] mem_addr_r,  mem_addr_s;
    logic [DATA_W-1:0] mem_wdata_r, mem_wdata_s;
    logic              if_ack_r,    if_ack_s;
    logic              d_ack_r,     d_ack_s;
    logic [DATA_W-1:0] if_rdata_r,  if_rdata_s;
    logic [DATA_W-1:0] d_rdata_r,   d_rdata_s;

    // Next-state, arbitration and next values of every registered output.
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        mem_req_s   = 1'b0;
        mem_we_s    = 1'b0;
        mem_addr_s  = mem_addr_r;
        mem_wdata_s = mem_wdata_r;
        if_ack_s    = 1'b0;
        d_ack_s     = 1'b0;
        if_rdata_s  = if_rdata_r;
        d_rdata_s   = d_rdata_r;
        case (state_r)
            IDLE: begin
                if (d_req && if_req && (cnt_r == CNT_MAX)) begin
                    // Fetch has waited through a full data burst: force it.
                    state_s    = BUSY_IF;
                    mem_req_s  = 1'b1;
                    mem_we_s   = 1'b0;
                    mem_addr_s = if_addr;
                    cnt_s      = '0;
                end else if (d_req) begin
                    state_s     = BUSY_D;
                    mem_req_s   = 1'b1;
                    mem_we_s    = d_we;
                    mem_addr_s  = d_addr;
                    mem_wdata_s = d_wdata;
                    if (if_req) begin
                        cnt_s = (cnt_r < CNT_MAX) ? (cnt_r + CNT_ONE) : cnt_r;
                    end else begin
                        cnt_s = '0;
                    end
                end else if (if_req) begin
                    state_s    = BUSY_IF;
                    mem_req_s  = 1'b1;
                    mem_we_s   = 1'b0;
                    mem_addr_s = if_addr;
                    cnt_s      = '0;
                end else begin
                    state_s = IDLE;
                end
            end
            BUSY_IF: begin
                if (mem_ready) begin
                    state_s    = RESP;
                    if_ack_s   = 1'b1;
                    if_rdata_s = mem_rdata;
                end else begin
                    mem_req_s = 1'b1;
                    mem_we_s  = mem_we_r;
                end
            end
            BUSY_D: begin
                if (mem_ready) begin
                    state_s = RESP;
                    d_ack_s = 1'b1;
                    // Store completions leave the last load result intact.
                    if (!mem_we_r) begin
                        d_rdata_s = mem_rdata;
                    end else begin
                        d_rdata_s = d_rdata_r;
                    end
                end else begin
                    mem_req_s = 1'b1;
                    mem_we_s  = mem_we_r;
                end
            end
            RESP: begin
                // Ack cycle: requesters update req on this edge, so no grant here.
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            cnt_r       <= '0;
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= '0;
            mem_wdata_r <= '0;
            if_ack_r    <= 1'b0;
            d_ack_r     <= 1'b0;
            if_rdata_r  <= '0;
            d_rdata_r   <= '0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            mem_req_r   <= mem_req_s;
            mem_we_r    <= mem_we_s;
            mem_addr_r  <= mem_addr_s;
            mem_wdata_r <= mem_wdata_s;
            if_ack_r    <= if_ack_s;
            d_ack_r     <= d_ack_s;
            if_rdata_r  <= if_rdata_s;
            d_rdata_r   <= d_rdata_s;
        end
    end

    assign mem_req   = mem_req_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign if_ack    = if_ack_r;
    assign d_ack     = d_ack_r;
    assign if_rdata  = if_rdata_r;
    assign d_rdata   = d_rdata_r;
    assign stall_if  = if_req & ~if_ack_r;
    assign stall_mem = d_req & ~d_ack_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter. A small memory responder answers
// mem_req after a programmable number of wait cycles and returns
// mem_addr ^ 32'h00A00083 as read data, so expected words are hand-computed.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ack;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ack;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        stall_if;
    logic        stall_mem;

    int          checks = 0;
    int          errors = 0;
    int          lat    = 0;
    int          busy_cnt = 0;
    logic        ready_force = 1'b0;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_DATA_BURST(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_ack    (if_ack),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_ack     (d_ack),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .stall_if  (stall_if),
        .stall_mem (stall_mem)
    );

    always #5 clk = ~clk;

    // Memory responder: counts cycles mem_req has been high.
    always @(posedge clk) begin
        busy_cnt <= mem_req ? busy_cnt + 1 : 0;
    end

    assign mem_ready = ready_force | (mem_req && (busy_cnt >= lat));
    assign mem_rdata = mem_addr ^ 32'h00A0_0083;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        if_req = 1'b0;
        d_req  = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Requests stay as driven; log acks in order (1 = data, 0 = fetch).
    task automatic record_events(input int n, output logic [15:0] seq, output int got);
        seq = 16'h0000;
        got = 0;
        for (int c = 0; c < 200 && got < n; c++) begin
            @(negedge clk);
            if (d_ack || if_ack) begin
                seq = {seq[14:0], d_ack};
                got++;
            end
        end
    endtask

    task automatic wait_d_ack(input string tag);
        for (int c = 0; c < 20 && !d_ack; c++) @(negedge clk);
        check(tag, {31'h0, d_ack}, 32'h1);
    endtask

    // Global time bound.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] seq;
        int          got;
        int          d_cyc;
        int          i_cyc;
        int          acks;
        logic        stall_ok;

        d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0;

        // Reset held with a pending fetch.
        rst = 1'b1; if_req = 1'b1; if_addr = 32'h0000_0010; d_req = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("rst_mem_req", {31'h0, mem_req}, 32'h0);
            check("rst_if_ack", {31'h0, if_ack}, 32'h0);
            check("rst_stall_if", {31'h0, stall_if}, 32'h1);
        end
        rst = 1'b0;

        // First fetch, zero wait states.
        @(negedge clk);
        check("f1_mem_req", {31'h0, mem_req}, 32'h1);
        check("f1_mem_addr", mem_addr, 32'h0000_0010);
        check("f1_mem_we", {31'h0, mem_we}, 32'h0);
        check("f1_if_ack_early", {31'h0, if_ack}, 32'h0);
        @(negedge clk);
        check("f1_if_ack", {31'h0, if_ack}, 32'h1);
        check("f1_if_rdata", if_rdata, 32'h00A0_0093);
        check("f1_mem_req_resp", {31'h0, mem_req}, 32'h0);
        check("f1_stall_if_off", {31'h0, stall_if}, 32'h0);
        if_req = 1'b0;
        @(negedge clk);
        check("f1_if_ack_pulse", {31'h0, if_ack}, 32'h0);

        // mem_ready in IDLE is ignored.
        ready_force = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_rdy_mem_req", {31'h0, mem_req}, 32'h0);
        check("idle_rdy_acks", {30'h0, if_ack, d_ack}, 32'h0);
        check("idle_rdy_if_rdata", if_rdata, 32'h00A0_0093);
        ready_force = 1'b0;

        // Simultaneous fetch and load: data first.
        do_reset();
        if_req = 1'b1; if_addr = 32'h0000_0040;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0200;
        stall_ok = 1'b1; d_cyc = 0; i_cyc = 0;
        for (int c = 1; c <= 20 && i_cyc == 0; c++) begin
            @(negedge clk);
            if (if_ack) begin
                i_cyc  = c;
                if_req = 1'b0;
            end else if (!stall_if) begin
                stall_ok = 1'b0;
            end else begin
                stall_ok = stall_ok;
            end
            if (d_ack) begin
                d_cyc = c;
                d_req = 1'b0;
            end
        end
        check("t3_d_ack_cycle", d_cyc, 32'd2);
        check("t3_if_ack_cycle", i_cyc, 32'd5);
        check("t3_d_rdata", d_rdata, 32'h00A0_0283);
        check("t3_if_rdata", if_rdata, 32'h00A0_00C3);
        check("t3_stall_if_held", {31'h0, stall_ok}, 32'h1);

        // Starvation guard: four data grants then a forced fetch.
        do_reset();
        if_req = 1'b1; if_addr = 32'h0000_0080;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0300;
        record_events(10, seq, got);
        check("t4_event_count", got, 32'd10);
        check("t4_ack_order", {16'h0, seq}, 32'h0000_03DE);
        d_req = 1'b0; if_req = 1'b0;

        // Store with three wait states after a load.
        do_reset();
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0204;
        wait_d_ack("t5_load_ack");
        d_req = 1'b0;
        check("t5_load_rdata", d_rdata, 32'h00A0_0287);
        @(negedge clk);
        lat = 3;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_0100; d_wdata = 32'hDEAD_BEEF;
        acks = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c <= 4) begin
                check("t5_mem_req", {31'h0, mem_req}, 32'h1);
                check("t5_mem_we", {31'h0, mem_we}, 32'h1);
                check("t5_mem_addr", mem_addr, 32'h0000_0100);
                check("t5_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
                check("t5_no_early_ack", {31'h0, d_ack}, 32'h0);
            end
            if (c == 5) check("t5_ack_cycle", {31'h0, d_ack}, 32'h1);
            if (d_ack) begin
                acks++;
                d_req = 1'b0;
            end
        end
        check("t5_single_ack", acks, 32'd1);
        check("t5_d_rdata_kept", d_rdata, 32'h00A0_0287);
        lat = 0; d_we = 1'b0;

        // Reset during a data access clears the burst counter.
        do_reset();
        if_req = 1'b1; if_addr = 32'h0000_0080;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0208;
        record_events(3, seq, got);
        check("t6_pre_events", {16'h0, seq}, 32'h0000_0007);
        lat = 5;
        repeat (2) @(negedge clk);
        check("t6_busy_mem_req", {31'h0, mem_req}, 32'h1);
        check("t6_busy_addr", mem_addr, 32'h0000_0208);
        rst = 1'b1;
        @(negedge clk);
        check("t6_rst_mem_req", {31'h0, mem_req}, 32'h0);
        check("t6_rst_d_ack", {31'h0, d_ack}, 32'h0);
        rst = 1'b0;
        lat = 0;
        record_events(5, seq, got);
        check("t6_post_count", got, 32'd5);
        check("t6_post_order", {16'h0, seq}, 32'h0000_001E);
        if_req = 1'b0; d_req = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
